// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU for the execute stage. It also holds the
// condition-code register that the branch/cmov logic reads.
//
// Optional build macro: ALU_PIPE_SAT_EN. When it is defined, ADD/SUB saturate
// on signed overflow instead of wrapping.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      input handshake
//   in_op, in_a, in_b        opcode and signed operands
//   in_set_cc                update condition codes when this op commits
//   out_valid / out_ready    output handshake
//   out_result, out_overflow result and signed-overflow flag (ADD/SUB only)
//   cc_zf, cc_sf, cc_of      condition-code register
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid && ready are both high. A producer holds valid and its payload steady
// until that transfer. in_ready depends combinationally on out_ready, so a
// full pipeline can accept a new op on the same edge that it retires one.
module alu_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SAR = 3'b111;

    // Stage 1: registered operation
    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_set_cc;

    // Stage 2: registered result
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_overflow;
    logic             s2_set_cc;

    logic s2_ready;
    logic in_accept;
    logic s1_advance;
    logic out_commit;

    assign s2_ready   = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s2_ready;
    assign in_accept  = in_valid && in_ready;
    assign s1_advance = s1_valid && s2_ready;
    assign out_commit = s2_valid && out_ready;

    // Execute logic, evaluated on the stage-1 contents
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   sum;
    logic               is_arith;
    logic               arith_ovf;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_result;

    always_comb begin
        // SUB is A + ~B + 1; overflow is judged on the sign of ~B, which also
        // covers subtracting the most negative value.
        b_eff     = (s1_op == OP_SUB) ? ~s1_b : s1_b;
        sum       = s1_a + b_eff + {{(WIDTH-1){1'b0}}, (s1_op == OP_SUB)};
        is_arith  = (s1_op == OP_ADD) || (s1_op == OP_SUB);
        arith_ovf = is_arith && (s1_a[WIDTH-1] == b_eff[WIDTH-1])
                             && (sum[WIDTH-1] != s1_a[WIDTH-1]);
        shamt     = s1_b[SHAMT_W-1:0];
        alu_result = '0;
        case (s1_op)
            OP_ADD, OP_SUB: begin
`ifdef ALU_PIPE_SAT_EN
                // A positive overflow can only come from non-negative A.
                if (arith_ovf)
                    alu_result = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                else
                    alu_result = sum;
`else
                alu_result = sum;
`endif
            end
            OP_AND:  alu_result = s1_a & s1_b;
            OP_XOR:  alu_result = s1_a ^ s1_b;
            OP_OR:   alu_result = s1_a | s1_b;
            OP_SHL:  alu_result = s1_a << shamt;
            OP_SHR:  alu_result = s1_a >> shamt;
            OP_SAR:  alu_result = $signed(s1_a) >>> shamt;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_set_cc <= 1'b0;
        end else begin
            if (in_accept) begin
                s1_valid  <= 1'b1;
                s1_op     <= in_op;
                s1_a      <= in_a;
                s1_b      <= in_b;
                s1_set_cc <= in_set_cc;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Result registers only change on a reload, so they hold while stalled
    // and keep their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_result   <= '0;
            s2_overflow <= 1'b0;
            s2_set_cc   <= 1'b0;
        end else begin
            if (s1_advance) begin
                s2_valid    <= 1'b1;
                s2_result   <= alu_result;
                s2_overflow <= arith_ovf;
                s2_set_cc   <= s1_set_cc;
            end else if (out_commit) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_zf <= 1'b1;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
        end else if (out_commit && s2_set_cc) begin
            cc_zf <= (s2_result == '0);
            cc_sf <= s2_result[WIDTH-1];
            cc_of <= s2_overflow;
        end
    end

    assign out_valid    = s2_valid;
    assign out_result   = s2_result;
    assign out_overflow = s2_overflow;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    localparam int W = 64;
    localparam logic [W-1:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, XOR_ = 3'b011;
    localparam logic [2:0] OR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, SAR = 3'b111;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_set_cc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_overflow;
    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: issue one op into an idle pipeline with out_ready=1, return its
    // result and the number of edges from accept to out_valid, then let it commit
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sc, output logic [W-1:0] res, output logic ovf,
                          output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_set_cc = sc; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_result;
        ovf = out_overflow;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_set_cc = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_result !== '0) begin errors++; $display("FAIL reset_out_result: got %h want 0", out_result); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", out_overflow); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("FAIL reset_cc: got %b want 100", {cc_zf, cc_sf, cc_of}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [W-1:0] res; logic ovf; int lat;
        run_op(ADD, 64'd5, 64'd7, 1'b1, res, ovf, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
        checks++; if (res !== 64'd12) begin errors++; $display("FAIL add_result: got %h want c", res); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_overflow: got %b want 0", ovf); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin errors++; $display("FAIL add_cc: got %b want 000", {cc_zf, cc_sf, cc_of}); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] res; logic ovf; int lat;
        // MAX - (-1): positive overflow
        run_op(SUB, MAXV, ONES, 1'b1, res, ovf, lat);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sub_pos_ovf_flag: got %b want 1", ovf); end
`ifdef ALU_PIPE_SAT_EN
        checks++; if (res !== MAXV) begin errors++; $display("FAIL sub_pos_ovf_result: got %h want %h", res, MAXV); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b001) begin errors++; $display("FAIL sub_pos_ovf_cc: got %b want 001", {cc_zf, cc_sf, cc_of}); end
`else
        checks++; if (res !== MINV) begin errors++; $display("FAIL sub_pos_ovf_result: got %h want %h", res, MINV); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin errors++; $display("FAIL sub_pos_ovf_cc: got %b want 011", {cc_zf, cc_sf, cc_of}); end
`endif
        // MIN + MIN: negative overflow
        run_op(ADD, MINV, MINV, 1'b1, res, ovf, lat);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_neg_ovf_flag: got %b want 1", ovf); end
`ifdef ALU_PIPE_SAT_EN
        checks++; if (res !== MINV) begin errors++; $display("FAIL add_neg_ovf_result: got %h want %h", res, MINV); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin errors++; $display("FAIL add_neg_ovf_cc: got %b want 011", {cc_zf, cc_sf, cc_of}); end
`else
        checks++; if (res !== '0) begin errors++; $display("FAIL add_neg_ovf_result: got %h want 0", res); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b101) begin errors++; $display("FAIL add_neg_ovf_cc: got %b want 101", {cc_zf, cc_sf, cc_of}); end
`endif
        // 0 - MIN: overflows positively
        run_op(SUB, 64'd0, MINV, 1'b0, res, ovf, lat);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sub_min_ovf_flag: got %b want 1", ovf); end
`ifdef ALU_PIPE_SAT_EN
        checks++; if (res !== MAXV) begin errors++; $display("FAIL sub_min_result: got %h want %h", res, MAXV); end
`else
        checks++; if (res !== MINV) begin errors++; $display("FAIL sub_min_result: got %h want %h", res, MINV); end
`endif
        // -1 - 1 = -2, no overflow
        run_op(SUB, ONES, 64'd1, 1'b0, res, ovf, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE || ovf !== 1'b0) begin errors++; $display("FAIL sub_plain: got %h/%b want fffffffffffffffe/0", res, ovf); end
    endtask

    task automatic test_logic();
        logic [W-1:0] res; logic ovf; int lat;
        logic [W-1:0] a = 64'h00FF_00FF_F0F0_1234;
        logic [W-1:0] b = 64'h0F0F_0F0F_FF00_00FF;
        run_op(AND_, a, b, 1'b0, res, ovf, lat);
        checks++; if (res !== 64'h000F_000F_F000_0034) begin errors++; $display("FAIL and_result: got %h want 000f000ff0000034", res); end
        run_op(XOR_, a, b, 1'b0, res, ovf, lat);
        checks++; if (res !== 64'h0FF0_0FF0_0FF0_12CB) begin errors++; $display("FAIL xor_result: got %h want 0ff00ff00ff012cb", res); end
        run_op(OR_, a, b, 1'b0, res, ovf, lat);
        checks++; if (res !== 64'h0FFF_0FFF_FFF0_12FF || ovf !== 1'b0) begin errors++; $display("FAIL or_result: got %h/%b want 0fff0ffffff012ff/0", res, ovf); end
    endtask

    task automatic test_shifts();
        logic [W-1:0] res; logic ovf; int lat;
        logic [W-1:0] a = 64'h8000_0000_0000_00F0;
        run_op(SHL, a, 64'h104, 1'b0, res, ovf, lat);
        checks++; if (res !== 64'h0000_0000_0000_0F00) begin errors++; $display("FAIL shl_result: got %h want 0000000000000f00", res); end
        run_op(SHR, a, 64'h104, 1'b0, res, ovf, lat);
        checks++; if (res !== 64'h0800_0000_0000_000F) begin errors++; $display("FAIL shr_result: got %h want 080000000000000f", res); end
        run_op(SAR, a, 64'h104, 1'b0, res, ovf, lat);
        checks++; if (res !== 64'hF800_0000_0000_000F) begin errors++; $display("FAIL sar_result: got %h want f80000000000000f", res); end
        run_op(SAR, MINV, 64'h3F, 1'b0, res, ovf, lat);
        checks++; if (res !== ONES) begin errors++; $display("FAIL sar_max_shift: got %h want ffffffffffffffff", res); end
        run_op(SHL, 64'd1, 64'h7F, 1'b0, res, ovf, lat);
        checks++; if (res !== MINV) begin errors++; $display("FAIL shl_max_shift: got %h want %h", res, MINV); end
        run_op(SHR, MINV, 64'hFFC0, 1'b0, res, ovf, lat);
        checks++; if (res !== MINV) begin errors++; $display("FAIL shr_zero_amount: got %h want %h", res, MINV); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   t_op[8]  = '{ADD, SUB, AND_, XOR_, OR_, SHL, SHR, SAR};
        logic [W-1:0] t_a[8]   = '{64'd1, 64'd10, 64'hFF, 64'hAA, 64'h100, 64'd1, 64'h800, 64'hFFFF_FFFF_FFFF_FFF0};
        logic [W-1:0] t_b[8]   = '{64'd2, 64'd3, 64'h0F, 64'h0F, 64'h01, 64'd8, 64'd4, 64'd2};
        logic [W-1:0] t_exp[8] = '{64'd3, 64'd7, 64'h0F, 64'hA5, 64'h101, 64'h100, 64'h80, 64'hFFFF_FFFF_FFFF_FFFC};
        logic         pat[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] exp_q[$];
        logic [W-1:0] held = '0;
        logic         prev_stall = 1'b0;
        logic         acc, com, exp_rdy;
        int sent = 0, got = 0, cyc = 0;
        while (got < 8 && cyc < 100) begin
            @(negedge clk);
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 8);
            in_set_cc = 1'b0;
            if (sent < 8) begin
                in_op = t_op[sent]; in_a = t_a[sent]; in_b = t_b[sent];
            end
            #1;
            if (prev_stall) begin
                checks++; if (out_result !== held) begin errors++; $display("FAIL b2b_stall_hold: got %h want %h", out_result, held); end
            end
            exp_rdy = !((sent - got) == 2 && !out_ready);
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready: cycle %0d got %b want %b", cyc, in_ready, exp_rdy); end
            acc = in_valid && in_ready;
            com = out_valid && out_ready;
            if (com) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_output: got %h want none", out_result);
                end else if (out_result !== exp_q[0]) begin
                    errors++; $display("FAIL b2b_order: got %h want %h", out_result, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            held = out_result;
            @(posedge clk);
            if (com) got++;
            if (acc) begin
                exp_q.push_back(t_exp[sent]);
                sent++;
            end
            cyc++;
        end
        checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d results want 8", got); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: out_valid %b pending %0d want 0/0", out_valid, exp_q.size()); end
    endtask

    task automatic test_cc_gating();
        logic [W-1:0] res; logic ovf; int lat;
        run_op(SUB, 64'd3, 64'd3, 1'b1, res, ovf, lat);
        checks++; if (res !== '0 || {cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("FAIL cc_sub_zero: got %h/%b want 0/100", res, {cc_zf, cc_sf, cc_of}); end
        run_op(XOR_, 64'd1, 64'd0, 1'b0, res, ovf, lat);
        checks++; if (res !== 64'd1) begin errors++; $display("FAIL cc_xor_result: got %h want 1", res); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("FAIL cc_gated_hold: got %b want 100", {cc_zf, cc_sf, cc_of}); end
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0] res; logic ovf; int lat;
        run_op(ADD, ONES, 64'd0, 1'b1, res, ovf, lat);
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin errors++; $display("FAIL rst_setup_cc: got %b want 010", {cc_zf, cc_sf, cc_of}); end
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_op = ADD; in_a = 64'd1; in_b = 64'd1; in_set_cc = 1'b1;
        @(negedge clk);
        in_a = 64'd2; in_b = 64'd2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_setup_full: out_valid %b in_ready %b want 1/0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin errors++; $display("FAIL rst_mid_cc: got %b want 100", {cc_zf, cc_sf, cc_of}); end
        checks++; if (out_result !== '0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", out_result); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(ADD, 64'd2, 64'd2, 1'b0, res, ovf, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rst_after_latency: got %0d want 2", lat); end
        checks++; if (res !== 64'd4) begin errors++; $display("FAIL rst_after_result: got %h want 4", res); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_after_no_stale: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_logic();
        test_shifts();
        test_back_to_back();
        test_cc_gating();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
